// File: rtl/uart_change_sender_if.sv
// uart_change_sender_if: valid/ready byte handshake between the change sender and the UART transmitter.
interface uart_change_sender_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [CH_W-1:0]   tx_ch;
  modport master (output tx_valid, tx_data, tx_ch, input tx_ready);
  modport slave (input tx_valid, tx_data, tx_ch, output tx_ready);
endinterface

// File: rtl/uart_change_sender.sv
// uart_change_sender: sends a channel byte to the UART only on change or periodic refresh, round-robin fair.
// Optional UART_CHANNEL_TAG_EN prefixes every data byte with a {4'hA, channel} tag byte.
module uart_change_sender #(
  parameter int NUM_CH         = 3,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                     uart_clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  uart_change_sender_if.master     tx
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW1  = CH_W + 1;
  localparam int GW   = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int RW   = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
`ifdef UART_CHANNEL_TAG_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, SEND_TAG} state_t;
  logic [DATA_W-1:0] data_q;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
  state_t            state;
  logic [DATA_W-1:0] ch_q   [NUM_CH];
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] rflag, pend, rot;
  logic [CH_W-1:0]   rr, g;
  logic [CW1-1:0]    off, sum;
  logic [GW-1:0]     gcnt;
  logic              rtick;
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_CH; i++) pend[i] = (ch_q[i] != shadow[i]) | rflag[i];
  end
  // Rotate so bit 0 is the rr channel; the lowest set bit is the next grant.
  always_comb begin
    rot = NUM_CH'({pend, pend} >> rr);
    off = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) off = CW1'(k);
    sum = {1'b0, rr} + off;
    g = CH_W'(sum >= CW1'(NUM_CH) ? sum - CW1'(NUM_CH) : sum);
  end
  assign busy = (state != IDLE) | (|pend);
  generate
    if (REFRESH_CYCLES > 0) begin : g_ref
      logic [RW-1:0] rcnt;
      always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) rcnt <= '0;
        else rcnt <= rtick ? '0 : rcnt + RW'(1);
      end
      assign rtick = rcnt == RW'(REFRESH_CYCLES - 1);
    end else begin : g_noref
      assign rtick = 1'b0;
    end
  endgenerate
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      ch_q        <= '{default: '0};
      shadow      <= '{default: '0};
      rflag       <= '0;
      rr          <= '0;
      gcnt        <= '0;
      state       <= IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
      tx.tx_ch    <= '0;
`ifdef UART_CHANNEL_TAG_EN
      data_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_data[i*DATA_W +: DATA_W];
      case (state)
        IDLE: if (|pend) begin
          tx.tx_ch    <= g;
          tx.tx_valid <= 1'b1;
          rflag[g]    <= 1'b0;
`ifdef UART_CHANNEL_TAG_EN
          tx.tx_data  <= DATA_W'({4'hA, 4'(g)});
          data_q      <= ch_q[g];
          state       <= SEND_TAG;
`else
          tx.tx_data  <= ch_q[g];
          state       <= SEND;
`endif
        end
`ifdef UART_CHANNEL_TAG_EN
        SEND_TAG: if (tx.tx_ready) begin
          tx.tx_data <= data_q;
          state      <= SEND;
        end
`endif
        SEND: if (tx.tx_ready) begin
          shadow[tx.tx_ch] <= tx.tx_data;
          rr               <= tx.tx_ch == CH_W'(NUM_CH - 1) ? '0 : tx.tx_ch + CH_W'(1);
          tx.tx_valid      <= 1'b0;
          state            <= GAP_CYCLES > 0 ? GAP : IDLE;
        end
        GAP: begin
          gcnt  <= gcnt == GW'(GAP_CYCLES - 1) ? '0 : gcnt + GW'(1);
          state <= gcnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
      // Placed after the grant so a refresh landing on a grant cycle is not lost.
      if (rtick) rflag <= '1;
    end
  end
endmodule

// File: tb/tb_uart_change_sender.sv
// tb_uart_change_sender: randomized channel changes and tx_ready stalls checked against a transaction-level model;
// a second instance with REFRESH_CYCLES=100 is watched for per-channel refresh spacing.
module tb_uart_change_sender;
  localparam int NUM_CH = 3, DATA_W = 8, GAP = 2, W = NUM_CH * DATA_W;
  logic         uart_clk = 1'b0, rst = 1'b0, rst_r = 1'b0;
  logic [W-1:0] ch_data = '0;
  logic         busy, busy_r;
  int           errors = 0, checks = 0;
  uart_change_sender_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) txi ();
  uart_change_sender_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) txr ();
  uart_change_sender #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(GAP), .REFRESH_CYCLES(0)) dut (
    .uart_clk(uart_clk), .rst(rst), .ch_data(ch_data), .busy(busy), .tx(txi.master));
  uart_change_sender #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(GAP), .REFRESH_CYCLES(100)) dut_r (
    .uart_clk(uart_clk), .rst(rst_r), .ch_data({NUM_CH{8'h42}}), .busy(busy_r), .tx(txr.master));
  always #5 uart_clk = ~uart_clk;
  typedef struct {int ch; logic [7:0] d;} ent_t;
  ent_t         acc_q[$];
  logic [7:0]   shadow_m [NUM_CH];
  logic [W-1:0] cq_cur;
  logic [7:0]   d_m, last_tag;
  logic         prev_valid, acc_pend, tag_phase;
  int           rr_m, g_m, low_cnt, since_acc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [W-1:0] cq);
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (rr_m + k) % NUM_CH;
      if (cq[c*DATA_W +: DATA_W] != shadow_m[c]) return c;
    end
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) shadow_m[i] = '0;
    cq_cur = '0; rr_m = 0; g_m = 0; d_m = '0; prev_valid = 1'b0; acc_pend = 1'b0;
    tag_phase = 1'b0; low_cnt = 0; since_acc = 1000;
  endtask
  // One clock: drive at a negedge, then check what the DUT shows at the next negedge.
  task automatic step(input logic [W-1:0] d, input logic rdy);
    int e;
    logic [7:0] dexp;
    ent_t en;
    ch_data = d;
    txi.tx_ready = rdy;
    acc_pend = prev_valid && rdy;
    @(negedge uart_clk);
    if (acc_pend && tag_phase) tag_phase = 1'b0;
    else if (acc_pend) begin
      shadow_m[g_m] = d_m;
      rr_m = (g_m + 1) % NUM_CH;
      en.ch = g_m; en.d = d_m;
      acc_q.push_back(en);
      since_acc = 0;
    end
    e = pick(cq_cur);
    dexp = e >= 0 ? cq_cur[e*DATA_W +: DATA_W] : 8'h00;
    cq_cur = d;
    if (txi.tx_valid && !prev_valid) begin
      check("grant_ch", 32'(txi.tx_ch), e);
      check("gap_len", since_acc >= GAP, 1);
      g_m = e; d_m = dexp;
`ifdef UART_CHANNEL_TAG_EN
      tag_phase = 1'b1;
      last_tag = txi.tx_data;
      check("tag_byte", txi.tx_data, {24'h0, 4'hA, 4'(e)});
`else
      check("grant_data", txi.tx_data, dexp);
`endif
    end else if (txi.tx_valid) begin
      check("hold_ch", 32'(txi.tx_ch), g_m);
      check("hold_data", txi.tx_data, tag_phase ? {24'h0, 4'hA, 4'(g_m)} : {24'h0, d_m});
    end
    if (txi.tx_valid) begin
      low_cnt = 0;
      check("busy_hi", busy, 1);
    end else begin
      since_acc++;
      low_cnt = e >= 0 ? low_cnt + 1 : 0;
      check("starve", low_cnt > GAP + 2, 0);
    end
    prev_valid = txi.tx_valid;
  endtask
  task automatic idle(input int n, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) step(d, 1'b1);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", txi.tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", txi.tx_data, 0);
    check("rst_ch", 32'(txi.tx_ch), 0);
    @(negedge uart_clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic check_acc(input string tag, input int i, input int ch, input logic [7:0] d);
    if (i < acc_q.size()) begin
      check({tag, "_ch"}, acc_q[i].ch, ch);
      check({tag, "_data"}, acc_q[i].d, d);
    end else check({tag, "_missing"}, acc_q.size(), i + 1);
  endtask
  int cyc = 0, r_bad = 0;
  int r_cnt [NUM_CH];
  int r_last [NUM_CH];
  initial for (int i = 0; i < NUM_CH; i++) begin r_cnt[i] = 0; r_last[i] = 0; end
  always @(negedge uart_clk) begin
    cyc++;
    if (!rst_r && txr.tx_valid && txr.tx_ready && txr.tx_data == 8'h42) begin
      if (r_cnt[txr.tx_ch] >= 2 && cyc - r_last[txr.tx_ch] != 100) r_bad++;
      r_cnt[txr.tx_ch]++;
      r_last[txr.tx_ch] = cyc;
    end
  end
  initial begin
    logic [W-1:0] d;
    txi.tx_ready = 1'b1;
    txr.tx_ready = 1'b1;
    model_reset();
    #1 rst = 1'b1; rst_r = 1'b1;
    #1;
    check("init_valid", txi.tx_valid, 0);
    check("init_busy", busy, 0);
    repeat (3) @(negedge uart_clk);
    rst = 1'b0; rst_r = 1'b0;
    d = '0;
    for (int i = 0; i < 50; i++) begin
      step(d, 1'b1);
      check("quiet_valid", txi.tx_valid, 0);
      check("quiet_busy", busy, 0);
    end
    acc_q.delete();
    d[1*DATA_W +: DATA_W] = 8'h37;
    step(d, 1'b1);
    check("lat_early", txi.tx_valid, 0);
    step(d, 1'b1);
    check("lat_valid", txi.tx_valid, 1);
    check("lat_ch", 32'(txi.tx_ch), 1);
    idle(20, d);
    check("single_count", acc_q.size(), 1);
    check_acc("single", 0, 1, 8'h37);
    d[0 +: DATA_W] = 8'h01;
    idle(20, d);
    acc_q.delete();
    d = {8'h33, 8'h22, 8'h11};
    idle(30, d);
    check("rr_count", acc_q.size(), 3);
    check_acc("rr0", 0, 1, 8'h22);
    check_acc("rr1", 1, 2, 8'h33);
    check_acc("rr2", 2, 0, 8'h11);
    acc_q.delete();
    d[0 +: DATA_W] = 8'h05;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) d[0 +: DATA_W] = 8'h06;
      step(d, 1'b0);
    end
    idle(30, d);
    check("stall_count", acc_q.size(), 2);
    check_acc("stall0", 0, 0, 8'h05);
    check_acc("stall1", 1, 0, 8'h06);
    d[2*DATA_W +: DATA_W] = 8'h9C;
    for (int i = 0; i < 3; i++) step(d, 1'b0);
    check("pre_rst_valid", txi.tx_valid, 1);
    do_reset();
    acc_q.delete();
    idle(30, d);
    check("resend_count", acc_q.size(), 3);
    check_acc("resend0", 0, 0, 8'h06);
    check_acc("resend1", 1, 1, 8'h22);
    check_acc("resend2", 2, 2, 8'h9C);
`ifdef UART_CHANNEL_TAG_EN
    check("last_tag", last_tag, 8'hA2);
`endif
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c = $urandom_range(0, NUM_CH - 1);
        d[c*DATA_W +: DATA_W] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      step(d, $urandom_range(0, 3) != 0);
    end
    idle(40, d);
    check("drain_valid", txi.tx_valid, 0);
    check("drain_busy", busy, 0);
    for (int i = 0; i < NUM_CH; i++) check("ref_count", r_cnt[i] >= 10, 1);
    check("ref_spacing", r_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_change_sender.md
Name: uart_change_sender

Overview:
- Parametrised successor to the fixed three-way UART send poller.
- Watches NUM_CH game-state channels and queues a byte only when a channel's value changes, or when a periodic refresh is due.
- Serialises those bytes to the UART transmitter with a valid/ready handshake and round-robin fairness.
- Sits between the traveller/game-state logic and the UART TX module.

Parameters:
- NUM_CH, 3, number of input channels (1..16).
- DATA_W, 8, width of each channel and of tx_data.
- GAP_CYCLES, 2, idle uart_clk cycles forced between accepted bytes (0 allowed).
- REFRESH_CYCLES, 0, period in uart_clk cycles for resending all channels; 0 disables refresh.

Ports:
- uart_clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- ch_data  in  NUM_CH*DATA_W  packed channel values; channel i is at bits [i*DATA_W +: DATA_W].
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  DATA_W  byte to transmit.
- tx_ch  out  max(1,$clog2(NUM_CH))  channel index of the current byte.
- busy  out  1  high in any state other than IDLE, or while any pending bit is set.

Behaviour:
- Reset: asynchronous, active-high.
  - Outputs: tx_valid=0, tx_data=0, tx_ch=0, busy=0.
  - Internal: ch_q, shadow and refresh flags cleared; rr pointer=0; state=IDLE; gap and refresh counters=0.
- Input stage: ch_data is registered into ch_q every cycle.
- Pending per channel: pend[i] = (ch_q[i] != shadow[i]) | refresh_flag[i].
  - Because shadow resets to 0, any channel that is nonzero after reset gets sent.
  - A value that changes and then reverts to shadow before being granted is never sent.
- Arbitration: round-robin. Search starts at rr and wraps from NUM_CH-1 to 0. With a single pending channel, that channel is chosen immediately.
- FSM states: IDLE, SEND, GAP.
  - IDLE → SEND when any pend bit is set:
    - load tx_data=ch_q[g], tx_ch=g, tx_valid=1;
    - clear refresh_flag[g].
  - SEND: tx_data and tx_ch stay stable while tx_valid=1 and tx_ready=0.
  - SEND, on tx_valid & tx_ready in the same cycle:
    - shadow[g] ← latched tx_data;
    - rr ← g+1, wrapping;
    - tx_valid ← 0;
    - go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: a change applied before edge k gives tx_valid=1 after edge k+1, i.e. 2 cycles when idle.
- Channel changes while its byte is in flight:
  - the latched byte is still sent unchanged;
  - shadow receives the sent value, so the new value re-pends and goes out on a later grant.
- Refresh (REFRESH_CYCLES>0):
  - the counter counts in every state;
  - at terminal count it sets all refresh_flags and reloads;
  - a flag already set stays set, so refresh requests never stack.
- Reset mid-handshake: the byte is dropped, tx_valid falls asynchronously and shadow clears.

Optional Feature:
- Macro: UART_CHANNEL_TAG_EN.
- Enabled:
  - each grant emits two handshaked bytes: a tag byte {4'hA, tx_ch[3:0]}, zero-extended or truncated to DATA_W, then the data byte;
  - adds state SEND_TAG ahead of SEND, with no gap between tag and data;
  - shadow updates only after the data byte is accepted;
  - reset during the tag byte drops both bytes.
- Disabled: the data byte only; the SEND_TAG state does not exist.

Test Plan:
1. Reset with ch_data=0, tx_ready=1, then hold for 50 cycles → tx_valid stays 0 and busy=0.
2. Channel 1 changes 0x00→0x37 with tx_ready=1 → exactly one byte: tx_data=0x37, tx_ch=1, tx_valid high 2 cycles after the change; no repeat afterwards.
3. Channels 0, 1 and 2 change in the same cycle to 0x11, 0x22, 0x33, with rr=1 and tx_ready=1 → send order ch1, ch2, ch0, with each acceptance separated by ≥GAP_CYCLES idle cycles.
4. tx_ready held 0 for 10 cycles while ch0=0x05, and ch0 changes to 0x06 mid-stall → 0x05 held stable until accepted, then 0x06 sent next.
5. REFRESH_CYCLES=100 with all channels static at 0x42 → every channel resent once per 100 cycles; no duplicates inside a period.
6. Reset asserted during SEND with tx_ready=0 → tx_valid=0 immediately; after release, nonzero channels are resent. With UART_CHANNEL_TAG_EN defined: a ch2 change to 0x9C produces tag 0xA2 then 0x9C.
